// File: rtl/ctrl_pipe.sv
// ============================================================================
//  Module   : ctrl_pipe
//  Purpose  : ID/EX, EX/MEM, MEM/WB control pipeline with EX-stage branch
//             resolution, wrong-path flush and external stall. Build option
//             CTRL_PIPE_LOAD_USE_EN enables the one-bubble load-use interlock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe #(
   parameter int REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cp_valid,
   input  logic              i_cp_regdst,
   input  logic              i_cp_alusrc,
   input  logic              i_cp_branch,
   input  logic              i_cp_memread,
   input  logic              i_cp_memwrite,
   input  logic              i_cp_regwrite,
   input  logic              i_cp_memtoreg,
   input  logic [1:0]        i_cp_aluop,
   input  logic [REG_AW-1:0] i_cp_rs,
   input  logic [REG_AW-1:0] i_cp_rt,
   input  logic [REG_AW-1:0] i_cp_rd,
   input  logic              i_cp_zero,
   input  logic              i_cp_stall,
   output logic              o_cp_ex_valid,
   output logic              o_cp_ex_regdst,
   output logic              o_cp_ex_alusrc,
   output logic [1:0]        o_cp_ex_aluop,
   output logic              o_cp_mem_memread,
   output logic              o_cp_mem_memwrite,
   output logic [REG_AW-1:0] o_cp_mem_dest,
   output logic [REG_AW-1:0] o_cp_wb_dest,
   output logic              o_cp_wb_regwrite,
   output logic              o_cp_wb_memtoreg,
   output logic              o_cp_pcsrc,
   output logic              o_cp_flush_if,
   output logic              o_cp_stall_id
);

   logic              ex_valid, ex_regdst, ex_alusrc, ex_branch;
   logic              ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
   logic [1:0]        ex_aluop;
   logic [REG_AW-1:0] ex_rt, ex_rd, ex_dest;

   logic              mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
   logic [REG_AW-1:0] mem_dest;

   logic              wb_regwrite, wb_memtoreg;
   logic [REG_AW-1:0] wb_dest;

   logic              taken, load_use, id_bubble;

   assign ex_dest = ex_regdst ? ex_rd : ex_rt;
   assign taken   = ex_valid & ex_branch &
                    ((ex_aluop == 2'b11) ? ~i_cp_zero : i_cp_zero);

`ifdef CTRL_PIPE_LOAD_USE_EN
   assign load_use = ex_valid & ex_memread & (ex_dest != '0) & i_cp_valid &
                     ((ex_dest == i_cp_rs) | (ex_dest == i_cp_rt));
`else
   // Without the interlock the rs field has no consumer in this block.
   logic unused_id_rs;
   assign unused_id_rs = ^i_cp_rs;
   assign load_use     = 1'b0;
`endif

   assign id_bubble     = taken | load_use | ~i_cp_valid;
   assign o_cp_pcsrc    = taken & ~i_cp_stall;
   assign o_cp_flush_if = taken & ~i_cp_stall;
   assign o_cp_stall_id = load_use & ~i_cp_stall & ~taken;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         {ex_valid, ex_regdst, ex_alusrc, ex_branch}         <= '0;
         {ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg} <= '0;
         ex_aluop <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
      end else if (!i_cp_stall) begin
         if (id_bubble) begin
            {ex_valid, ex_regdst, ex_alusrc, ex_branch}         <= '0;
            {ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg} <= '0;
            ex_aluop <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
         end else begin
            ex_valid    <= 1'b1;
            ex_regdst   <= i_cp_regdst;
            ex_alusrc   <= i_cp_alusrc;
            ex_branch   <= i_cp_branch;
            ex_memread  <= i_cp_memread;
            ex_memwrite <= i_cp_memwrite;
            ex_regwrite <= i_cp_regwrite;
            ex_memtoreg <= i_cp_memtoreg;
            ex_aluop    <= i_cp_aluop;
            ex_rt       <= i_cp_rt;
            ex_rd       <= i_cp_rd;
         end
      end
   end

   // A taken branch travels on to MEM stripped of any side effect.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         {mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg} <= '0;
         mem_dest <= '0;
      end else if (!i_cp_stall) begin
         mem_memread  <= ex_memread  & ~taken;
         mem_memwrite <= ex_memwrite & ~taken;
         mem_regwrite <= ex_regwrite & ~taken;
         mem_memtoreg <= ex_memtoreg & ~taken;
         mem_dest     <= ex_dest;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wb_regwrite <= 1'b0;
         wb_memtoreg <= 1'b0;
         wb_dest     <= '0;
      end else if (!i_cp_stall) begin
         wb_regwrite <= mem_regwrite;
         wb_memtoreg <= mem_memtoreg;
         wb_dest     <= mem_dest;
      end
   end

   assign o_cp_ex_valid     = ex_valid;
   assign o_cp_ex_regdst    = ex_regdst;
   assign o_cp_ex_alusrc    = ex_alusrc;
   assign o_cp_ex_aluop     = ex_aluop;
   assign o_cp_mem_memread  = mem_memread;
   assign o_cp_mem_memwrite = mem_memwrite;
   assign o_cp_mem_dest     = mem_dest;
   assign o_cp_wb_dest      = wb_dest;
   assign o_cp_wb_regwrite  = wb_regwrite;
   assign o_cp_wb_memtoreg  = wb_memtoreg;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
// ============================================================================
//  Module   : tb_ctrl_pipe
//  Purpose  : Self-checking bench for ctrl_pipe against an instruction-level
//             pipeline model; honours CTRL_PIPE_LOAD_USE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe;

   localparam int AW = 5;
`ifdef CTRL_PIPE_LOAD_USE_EN
   localparam bit LU = 1'b1;
`else
   localparam bit LU = 1'b0;
`endif

   typedef struct packed {
      logic          valid, regdst, alusrc;
      logic [1:0]    aluop;
      logic          branch, memread, memwrite, regwrite, memtoreg;
      logic [AW-1:0] rs, rt, rd;
   } instr_t;

   // One in-flight instruction as the model sees it, destination resolved.
   typedef struct packed {
      logic          valid, regdst, alusrc;
      logic [1:0]    aluop;
      logic          branch, memread, memwrite, regwrite, memtoreg;
      logic [AW-1:0] dest;
   } stage_t;

   logic   clk = 1'b0, rst = 1'b1, zero = 1'b0, stall = 1'b0;
   instr_t id  = '0;

   logic          ex_valid, ex_regdst, ex_alusrc, mem_memread, mem_memwrite;
   logic [1:0]    ex_aluop;
   logic [AW-1:0] mem_dest, wb_dest;
   logic          wb_regwrite, wb_memtoreg, pcsrc, flush_if, stall_id;

   always #5 clk = ~clk;

   ctrl_pipe #(.REG_AW(AW)) dut (
      .i_clk(clk), .i_rst(rst), .i_cp_valid(id.valid),
      .i_cp_regdst(id.regdst), .i_cp_alusrc(id.alusrc), .i_cp_branch(id.branch),
      .i_cp_memread(id.memread), .i_cp_memwrite(id.memwrite),
      .i_cp_regwrite(id.regwrite), .i_cp_memtoreg(id.memtoreg),
      .i_cp_aluop(id.aluop), .i_cp_rs(id.rs), .i_cp_rt(id.rt), .i_cp_rd(id.rd),
      .i_cp_zero(zero), .i_cp_stall(stall),
      .o_cp_ex_valid(ex_valid), .o_cp_ex_regdst(ex_regdst),
      .o_cp_ex_alusrc(ex_alusrc), .o_cp_ex_aluop(ex_aluop),
      .o_cp_mem_memread(mem_memread), .o_cp_mem_memwrite(mem_memwrite),
      .o_cp_mem_dest(mem_dest), .o_cp_wb_dest(wb_dest),
      .o_cp_wb_regwrite(wb_regwrite), .o_cp_wb_memtoreg(wb_memtoreg),
      .o_cp_pcsrc(pcsrc), .o_cp_flush_if(flush_if), .o_cp_stall_id(stall_id)
   );

   int     n_chk = 0, n_fail = 0, cyc = 0;
   bit     model_ok = 1'b0;
   stage_t m_ex = '0, m_mem = '0, m_wb = '0;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic instr_t mk(bit rdst, bit asrc, bit [1:0] op, bit br, bit mr,
                                 bit mw, bit rw, bit m2r, bit [AW-1:0] s, bit [AW-1:0] t,
                                 bit [AW-1:0] d);
      instr_t x;
      x = '{valid:1'b1, regdst:rdst, alusrc:asrc, aluop:op, branch:br, memread:mr,
            memwrite:mw, regwrite:rw, memtoreg:m2r, rs:s, rt:t, rd:d};
      return x;
   endfunction

   function automatic instr_t addi(bit [AW-1:0] s, bit [AW-1:0] t);
      return mk(0, 1, 2'b00, 0, 0, 0, 1, 0, s, t, 0);
   endfunction
   function automatic instr_t rtype(bit [AW-1:0] s, bit [AW-1:0] t, bit [AW-1:0] d);
      return mk(1, 0, 2'b10, 0, 0, 0, 1, 0, s, t, d);
   endfunction
   function automatic instr_t lw(bit [AW-1:0] s, bit [AW-1:0] t);
      return mk(0, 1, 2'b00, 0, 1, 0, 1, 1, s, t, 0);
   endfunction
   function automatic instr_t sw(bit [AW-1:0] s, bit [AW-1:0] t);
      return mk(0, 1, 2'b00, 0, 0, 1, 0, 0, s, t, 0);
   endfunction
   function automatic instr_t br(bit [1:0] op, bit [AW-1:0] s, bit [AW-1:0] t);
      return mk(0, 0, op, 1, 0, 0, 0, 0, s, t, 0);
   endfunction

   function automatic bit m_taken();
      return m_ex.valid && m_ex.branch && ((m_ex.aluop == 2'b11) ? !zero : zero);
   endfunction

   function automatic bit m_lu();
      return LU && m_ex.valid && m_ex.memread && (m_ex.dest != 0) && id.valid &&
             (m_ex.dest == id.rs || m_ex.dest == id.rt);
   endfunction

   task automatic compare_all();
      check("ex_valid",     ex_valid,     m_ex.valid);
      check("ex_regdst",    ex_regdst,    m_ex.regdst);
      check("ex_alusrc",    ex_alusrc,    m_ex.alusrc);
      check("ex_aluop",     ex_aluop,     m_ex.aluop);
      check("mem_memread",  mem_memread,  m_mem.memread);
      check("mem_memwrite", mem_memwrite, m_mem.memwrite);
      check("mem_dest",     mem_dest,     m_mem.dest);
      check("wb_regwrite",  wb_regwrite,  m_wb.regwrite);
      check("wb_memtoreg",  wb_memtoreg,  m_wb.memtoreg);
      check("wb_dest",      wb_dest,      m_wb.dest);
      check("pcsrc",        pcsrc,        m_taken() && !stall);
      check("flush_if",     flush_if,     m_taken() && !stall);
      check("stall_id",     stall_id,     m_lu() && !stall && !m_taken());
   endtask

   task automatic model_update();
      bit     tk, lu;
      stage_t nx;
      tk = m_taken();
      lu = m_lu();
      if (rst) begin
         m_ex = '0; m_mem = '0; m_wb = '0;
      end else if (!stall) begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (tk) begin
            m_mem.regwrite = 1'b0; m_mem.memread  = 1'b0;
            m_mem.memwrite = 1'b0; m_mem.memtoreg = 1'b0;
         end
         nx = '{valid:1'b1, regdst:id.regdst, alusrc:id.alusrc, aluop:id.aluop,
                branch:id.branch, memread:id.memread, memwrite:id.memwrite,
                regwrite:id.regwrite, memtoreg:id.memtoreg,
                dest:(id.regdst ? id.rd : id.rt)};
         m_ex = (tk || lu || !id.valid) ? stage_t'(0) : nx;
      end
   endtask

   // Inputs are driven at the falling edge; outputs are compared 2 ns later.
   task automatic tick();
      #2;
      if (model_ok) compare_all();
      @(posedge clk);
      model_update();
      if (rst) model_ok = 1'b1;
      cyc++;
      @(negedge clk);
   endtask

   function automatic bit [AW-1:0] rreg();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
   endfunction

   function automatic instr_t rand_instr();
      instr_t x;
      case ($urandom_range(0, 9))
         0: begin x = instr_t'($urandom); x.valid = 1'b0; end
         1, 2: x = addi(rreg(), rreg());
         3, 4: x = rtype(rreg(), rreg(), rreg());
         5: x = lw(rreg(), rreg());
         6: x = sw(rreg(), rreg());
         7: x = br(2'b01, rreg(), rreg());
         8: x = br(2'b11, rreg(), rreg());
         default: begin x = instr_t'($urandom); x.valid = 1'b1; x.branch = 1'b0; end
      endcase
      return x;
   endfunction

   initial begin
      // Reset with random inputs
      rst = 1'b1; id = rand_instr(); zero = 1'($urandom); tick();
      id = rand_instr(); tick();
      check("rst_ex_valid", ex_valid, 0);
      check("rst_mem_dest", mem_dest, 0);
      check("rst_wb_regwrite", wb_regwrite, 0);
      check("rst_wb_dest", wb_dest, 0);
      check("rst_pcsrc", pcsrc, 0);
      check("rst_stall_id", stall_id, 0);
      rst = 1'b0; id = '0; zero = 1'b0;
      repeat (3) tick();
      check("bubble_wb_regwrite", wb_regwrite, 0);

      // ADDI walks the pipe
      id = addi(1, 5); tick();
      id = '0;
      check("addi_ex_alusrc", ex_alusrc, 1);
      tick();
      check("addi_mem_dest", mem_dest, 5);
      tick();
      check("addi_wb_regwrite", wb_regwrite, 1);
      check("addi_wb_dest", wb_dest, 5);

      // BEQ taken, then not taken
      id = br(2'b01, 1, 2); tick();
      zero = 1'b1; id = addi(2, 7); #1;
      check("beq_pcsrc", pcsrc, 1);
      check("beq_flush_if", flush_if, 1);
      tick();
      check("beq_ex_flushed", ex_valid, 0);
      id = br(2'b01, 1, 2); zero = 1'b0; tick();
      id = '0; #1;
      check("beq_nt_pcsrc", pcsrc, 0);
      tick();

      // BNE held by stall, taken when stall drops
      id = br(2'b11, 3, 4); tick();
      zero = 1'b0; stall = 1'b1; id = addi(3, 6); #1;
      check("bne_stall_pcsrc0", pcsrc, 0);
      tick();
      #1;
      check("bne_stall_pcsrc1", pcsrc, 0);
      check("bne_held_ex_valid", ex_valid, 1);
      check("bne_held_aluop", ex_aluop, 3);
      tick();
      stall = 1'b0; #1;
      check("bne_release_pcsrc", pcsrc, 1);
      tick();
      check("bne_ex_flushed", ex_valid, 0);

`ifdef CTRL_PIPE_LOAD_USE_EN
      // Load-use: exactly one bubble
      id = lw(1, 8); tick();
      id = rtype(8, 4, 10); #1;
      check("lu_stall_id", stall_id, 1);
      tick();
      check("lu_bubble", ex_valid, 0);
      #1;
      check("lu_stall_once", stall_id, 0);
      tick();
      check("lu_add_in_ex", ex_valid, 1);
      check("lu_add_regdst", ex_regdst, 1);
`endif
      id = lw(1, 0); tick();
      id = rtype(0, 0, 11); #1;
      check("lu_dest0_nostall", stall_id, 0);
      tick();
      id = lw(1, 8); tick();
      id = rtype(9, 9, 12); #1;
      check("lu_nomatch_nostall", stall_id, 0);
      tick();
      id = '0; repeat (3) tick();

      // Reset while an R-type sits in MEM
      id = rtype(1, 3, 12); tick();
      id = '0; tick();
      rst = 1'b1; tick();
      check("rst_mid_wb_regwrite", wb_regwrite, 0);
      check("rst_mid_wb_dest", wb_dest, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_mid_no_write", wb_regwrite, 0);
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         id    = rand_instr();
         zero  = 1'($urandom);
         stall = ($urandom_range(0, 9) == 0);
         rst   = ($urandom_range(0, 59) == 0);
         tick();
      end
      rst = 1'b0; stall = 1'b0; id = '0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
